// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen : parameterised raster timing generator with pixel-clock-enable
// Optional: define FRAME_COUNT_EN to add the 16-bit frame_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       polarity,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_stb,
  output logic       line_start,
  output logic       frame_start
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [3:0]  DIV_LAST   = 4'(PIX_DIV - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: PIX_DIV must be in 1..16");
  end

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, visible_q, visible_d;
  logic       pix_stb_q, pix_stb_d, line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       strobe, h_active, v_active;

  always_comb begin
    strobe   = enable && (div_q == DIV_LAST);
    h_active = ({1'b0, h_q} >= H_SYNC_BEG) && ({1'b0, h_q} < H_SYNC_END);
    v_active = ({1'b0, v_q} >= V_SYNC_BEG) && ({1'b0, v_q} < V_SYNC_END);

    div_d = div_q;
    if (enable) begin
      div_d = strobe ? 4'd0 : 4'(div_q + 4'd1);
    end

    h_d = h_q;
    v_d = v_q;
    if (strobe) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : 10'(v_q + 10'd1);
      end else begin
        h_d = 10'(h_q + 10'd1);
      end
    end

    // Level outputs hold between strobes; pulses default low.
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    visible_d     = visible_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    pix_stb_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (strobe) begin
      pix_x_d       = h_q;
      pix_y_d       = v_q;
      visible_d     = ({1'b0, h_q} < H_VIS_END) && ({1'b0, v_q} < V_VIS_END);
      hsync_d       = h_active ? polarity : ~polarity;
      vsync_d       = v_active ? polarity : ~polarity;
      pix_stb_d     = 1'b1;
      line_start_d  = (h_q == 10'd0);
      frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= 4'd0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      visible_q     <= 1'b0;
      hsync_q       <= ~polarity;
      vsync_q       <= ~polarity;
      pix_stb_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_stb_q     <= pix_stb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_stb     = pix_stb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef FRAME_COUNT_EN
  // The (0,0) load straight after reset is not a completed frame, so skip it.
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_seen_q, frame_seen_d;

  always_comb begin
    frame_count_d = frame_count_q;
    frame_seen_d  = frame_seen_q;
    if (frame_start_d) begin
      if (frame_seen_q) begin
        frame_count_d = 16'(frame_count_q + 16'd1);
      end
      frame_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= 16'd0;
      frame_seen_q  <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      frame_seen_q  <= frame_seen_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// tb_vga_sync_gen : directed self-checking bench for vga_sync_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset, en_a, en_b, pol_a, pol_b;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic       a_hs, a_vs, a_vis, a_stb, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_vis, b_stb, b_ls, b_fs;
  logic [9:0] b_x, b_y;
`ifdef FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  always #5 clk = ~clk;

  // Full 800-pixel lines, shortened 8-line frame so whole frames fit the run.
  vga_sync_gen #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIX_DIV(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .polarity(pol_a),
    .hsync(a_hs), .vsync(a_vs), .visible(a_vis), .pix_x(a_x), .pix_y(a_y),
    .pix_stb(a_stb), .line_start(a_ls), .frame_start(a_fs)
`ifdef FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_sync_gen #(.PIX_DIV(4)) u_dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .polarity(pol_b),
    .hsync(b_hs), .vsync(b_vs), .visible(b_vis), .pix_x(b_x), .pix_y(b_y),
    .pix_stb(b_stb), .line_start(b_ls), .frame_start(b_fs)
`ifdef FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int fs_cyc, hs_cnt, hs_first, hs_last, vs_cnt, vs_first, vs_last;
    int bad, stb_cnt, last_stb;
    logic vis639, vis640;

    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; pol_a = 1'b0; pol_b = 1'b1;
    tick(); tick();
    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_vis", a_vis, 0);
    check("rst_pulses", {a_stb, a_ls, a_fs}, 0);
    check("rst_syncs_lowpol", {a_hs, a_vs}, 2'b11);
    check("rst_syncs_highpol", {b_hs, b_vs}, 2'b00);

    // First enabled clock loads (0,0)
    reset = 1'b0; en_a = 1'b1;
    tick();
    fs_cyc = cyc;
    check("first_xy", {a_x, a_y}, 0);
    check("first_vis", a_vis, 1);
    check("first_pulses", {a_stb, a_ls, a_fs}, 3'b111);
    check("first_syncs", {a_hs, a_vs}, 2'b11);
`ifdef FRAME_COUNT_EN
    check("first_fc", a_fc, 0);
`endif
    tick();
    check("second_x", a_x, 1);
    check("second_fs", a_fs, 0);

    // Line 0 scan up to x=799
    hs_cnt = 0; hs_first = 1023; hs_last = 0; vis639 = 1'b0; vis640 = 1'b1;
    for (int i = 0; i < 798; i++) begin
      tick();
      if (a_x == 10'd639) vis639 = a_vis;
      if (a_x == 10'd640) vis640 = a_vis;
      if (!a_hs) begin
        hs_cnt++;
        if (int'(a_x) < hs_first) hs_first = int'(a_x);
        if (int'(a_x) > hs_last) hs_last = int'(a_x);
      end
    end
    check("vis_639", vis639, 1);
    check("vis_640", vis640, 0);
    check("hs_len", hs_cnt, 96);
    check("hs_first", hs_first, 656);
    check("hs_last", hs_last, 751);
    check("line_end_xy", {a_x, a_y}, {10'd799, 10'd0});
    tick();
    check("line_wrap_xy", {a_x, a_y}, {10'd0, 10'd1});
    check("line_wrap_pulses", {a_ls, a_fs}, 2'b10);

    // Rest of frame: vsync low on lines 5..6 of the 8-line frame
    vs_cnt = 0; vs_first = 1023; vs_last = 0;
    for (int i = 0; i < 5599; i++) begin
      tick();
      if (!a_vs) begin
        vs_cnt++;
        if (int'(a_y) < vs_first) vs_first = int'(a_y);
        if (int'(a_y) > vs_last) vs_last = int'(a_y);
      end
    end
    check("vs_len", vs_cnt, 1600);
    check("vs_first", vs_first, 5);
    check("vs_last", vs_last, 6);
    check("frame_end_xy", {a_x, a_y}, {10'd799, 10'd7});
    check("frame_end_fs", a_fs, 0);
    tick();
    check("frame_wrap_xy", {a_x, a_y}, 0);
    check("frame_wrap_pulses", {a_ls, a_fs}, 2'b11);
    check("frame_period", cyc - fs_cyc, 6400);
    fs_cyc = cyc;
`ifdef FRAME_COUNT_EN
    check("fc_one", a_fc, 1);
`endif

    // Hold at x=100 for 10 clocks
    for (int i = 0; i < 100; i++) tick();
    check("hold_pre_x", a_x, 100);
    en_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_x != 10'd100 || a_stb || a_ls || a_fs) bad++;
    end
    check("hold_bad_clocks", bad, 0);
    check("hold_x", a_x, 100);
    en_a = 1'b1;
    tick();
    check("resume_x", a_x, 101);
    check("resume_stb", a_stb, 1);

    // Second full frame
    for (int i = 0; i < 6298; i++) tick();
    tick();
    check("frame2_pulses", {a_ls, a_fs}, 2'b11);
    check("frame2_period", cyc - fs_cyc, 6410);
`ifdef FRAME_COUNT_EN
    check("fc_two", a_fc, 2);
`endif

    // Reset mid-line at (300,3)
    for (int i = 0; i < 2700; i++) tick();
    check("pre_rst_xy", {a_x, a_y}, {10'd300, 10'd3});
    reset = 1'b1;
    tick();
    check("midrst_xy", {a_x, a_y}, 0);
    check("midrst_vis", a_vis, 0);
    check("midrst_pulses", {a_stb, a_ls, a_fs}, 0);
    check("midrst_syncs", {a_hs, a_vs}, 2'b11);
`ifdef FRAME_COUNT_EN
    check("midrst_fc", a_fc, 0);
`endif
    reset = 1'b0;
    tick();
    check("restart_xy", {a_x, a_y}, 0);
    check("restart_fs", a_fs, 1);
`ifdef FRAME_COUNT_EN
    check("restart_fc", a_fc, 0);
`endif
    en_a = 1'b0;

    // PIX_DIV=4, active-high sync
    en_b = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_stb || b_vis) bad++;
    end
    check("div4_prestrobe", bad, 0);
    tick();
    check("div4_first_stb", b_stb, 1);
    check("div4_first_xy", {b_x, b_y}, 0);
    check("div4_first_vis", b_vis, 1);
    check("div4_first_hs", b_hs, 0);
    last_stb = cyc; stb_cnt = 0; bad = 0;
    hs_cnt = 0; hs_first = 1023; hs_last = 0;
    for (int i = 0; i < 3200; i++) begin
      tick();
      if (b_stb) begin
        stb_cnt++;
        if (cyc - last_stb != 4) bad++;
        last_stb = cyc;
      end
      if (b_hs) begin
        hs_cnt++;
        if (int'(b_x) < hs_first) hs_first = int'(b_x);
        if (int'(b_x) > hs_last) hs_last = int'(b_x);
      end
    end
    check("div4_stb_count", stb_cnt, 800);
    check("div4_stb_gaps", bad, 0);
    check("div4_hs_clocks", hs_cnt, 384);
    check("div4_hs_first", hs_first, 656);
    check("div4_hs_last", hs_last, 751);
    check("div4_line_xy", {b_x, b_y}, {10'd0, 10'd1});
    check("div4_line_pulses", {b_stb, b_ls}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
